// File: rtl/phy_tx_pkg.sv
// ---------------------------------------------------------------------------
// phy_tx_pkg
// Shared definitions for the phy_TX link-level blocks: 8b symbol codes, the
// 32-bit ordered words built from them, and the link sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package phy_tx_pkg;

  // Symbol codes
  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] SKP    = 8'h1C;
  localparam logic [7:0] IDL    = 8'h7C;

  // Ordered words: a comma-led word for TS1/SKP, all-idle otherwise
  localparam logic [31:0] TS1_WORD  = {COM, TS1_ID, TS1_ID, TS1_ID};
  localparam logic [31:0] SKP_WORD  = {COM, SKP, SKP, SKP};
  localparam logic [31:0] IDLE_WORD = {IDL, IDL, IDL, IDL};

  typedef enum logic [2:0] {
    DISABLED  = 3'd0,
    TRAIN     = 3'd1,
    WAIT_LOCK = 3'd2,
    ACTIVE    = 3'd3,
    SKIP      = 3'd4
  } link_state_e;

  // Link is considered up while carrying payload or inserting SKP words
  function automatic logic is_link_up(input link_state_e s);
    return (s == ACTIVE) || (s == SKIP);
  endfunction

endpackage

// File: rtl/phy_tx_skip_timer.sv
// ---------------------------------------------------------------------------
// phy_tx_skip_timer
// Paces SKP ordered-word insertion. Counts cycles spent in the payload state
// and flags when an insertion is due, then counts the insertion length.
// Counters are cleared whenever the owning FSM does not stay in the state
// they time, so every entry into that state starts from zero.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   cur_active   FSM is in its payload state this cycle
//   nxt_active   FSM stays in / enters its payload state at the next edge
//   cur_skip     FSM is in its SKP insertion state this cycle
//   nxt_skip     FSM stays in / enters its SKP insertion state next edge
//   skip_due     insertion due now (last payload cycle of the interval)
//   skip_done    last SKP word of the insertion is being sent now
// ---------------------------------------------------------------------------
module phy_tx_skip_timer #(
  parameter int SKIP_INTERVAL = 64,
  parameter int SKIP_LEN      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cur_active,
  input  logic nxt_active,
  input  logic cur_skip,
  input  logic nxt_skip,
  output logic skip_due,
  output logic skip_done
);

  localparam int SCW = $clog2(SKIP_INTERVAL + 1);
  localparam int SLW = $clog2(SKIP_LEN + 1);
  localparam logic [SCW-1:0] SKIP_LAST = SCW'(SKIP_INTERVAL - 1);
  localparam logic [SLW-1:0] LEN_LAST  = SLW'(SKIP_LEN - 1);

  logic [SCW-1:0] skip_cnt;
  logic [SLW-1:0] len_cnt;

  assign skip_due  = cur_active && (skip_cnt == SKIP_LAST);
  assign skip_done = cur_skip && (len_cnt == LEN_LAST);

  // Both counters stop at their last value because the FSM always leaves the
  // timed state on that cycle, so neither can wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt <= '0;
      len_cnt  <= '0;
    end else begin
      skip_cnt <= (cur_active && nxt_active) ? skip_cnt + SCW'(1) : '0;
      len_cnt  <= (cur_skip && nxt_skip) ? len_cnt + SLW'(1) : '0;
    end
  end

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// ---------------------------------------------------------------------------
// phy_tx_link_ctrl
// Link-level sequencer feeding the phy_TX lane datapath. Trains the link with
// TS1 words until the far end locks, then forwards payload words, inserting
// SKP ordered words periodically. Retries training on lock timeout and raises
// a sticky error once retries are exhausted.
//
// Handshake: a payload word moves when valid_in && ready_out are both high at
// a rising clk_f edge. ready_out is combinational and already folds in
// link_enable, rx_lock and a due SKP insertion, so an accepted word is never
// dropped; valid_in may be held with data_in stable until ready_out is seen.
//
// Ports:
//   clk_f        clock
//   reset        asynchronous active-high reset
//   link_enable  request link bring-up; low forces DISABLED
//   rx_lock      far-end receiver symbol lock
//   data_in      payload word, valid_in qualifies it
//   ready_out    payload word accepted this cycle (with valid_in)
//   data_out     registered word to phy_TX
//   valid_out    registered valid to phy_TX
//   active_out   registered active to phy_TX
//   link_up      registered; state is ACTIVE or SKIP
//   link_error   registered, sticky until link_enable drops
// ---------------------------------------------------------------------------
module phy_tx_link_ctrl
  import phy_tx_pkg::*;
#(
  parameter int TS_COUNT      = 16,
  parameter int LOCK_TIMEOUT  = 255,
  parameter int MAX_RETRY     = 3,
  parameter int SKIP_INTERVAL = 64,
  parameter int SKIP_LEN      = 2
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        link_enable,
  input  logic        rx_lock,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active_out,
  output logic        link_up,
  output logic        link_error
);

  localparam int TSW = $clog2(TS_COUNT + 1);
  localparam int TOW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTW = $clog2(MAX_RETRY + 1);

  localparam logic [TSW-1:0] TS_LAST = TSW'(TS_COUNT - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(LOCK_TIMEOUT - 1);
  localparam logic [RTW-1:0] RT_MAX  = RTW'(MAX_RETRY);

  link_state_e    state_q, state_d;
  logic [TSW-1:0] ts_cnt_q, ts_cnt_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic [RTW-1:0] retry_q, retry_d;
  logic [RTW-1:0] retry_inc;
  logic           error_d;
  logic [31:0]    data_d;
  logic           valid_d;
  logic           active_d;
  logic           link_up_d;
  logic           skip_due;
  logic           skip_done;
  logic           xfer;

  phy_tx_skip_timer #(
    .SKIP_INTERVAL (SKIP_INTERVAL),
    .SKIP_LEN      (SKIP_LEN)
  ) u_skip_timer (
    .clk        (clk_f),
    .rst        (reset),
    .cur_active (state_q == ACTIVE),
    .nxt_active (state_d == ACTIVE),
    .cur_skip   (state_q == SKIP),
    .nxt_skip   (state_d == SKIP),
    .skip_due   (skip_due),
    .skip_done  (skip_done)
  );

  assign ready_out = (state_q == ACTIVE) && link_enable && rx_lock && !skip_due;
  assign xfer      = valid_in && ready_out;
  assign retry_inc = retry_q + RTW'(1);

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    error_d   = link_error;
    data_d    = '0;
    valid_d   = 1'b0;
    active_d  = 1'b0;

    case (state_q)
      DISABLED: begin
        if (link_enable && !link_error) begin
          state_d = TRAIN;
          retry_d = '0;
        end
      end
      TRAIN: begin
        data_d   = TS1_WORD;
        valid_d  = 1'b1;
        active_d = 1'b1;
        // rx_lock is deliberately not looked at until the TS1 burst completes
        if (ts_cnt_q == TS_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        data_d   = TS1_WORD;
        valid_d  = 1'b1;
        active_d = 1'b1;
        // Lock is tested first so it wins over a simultaneous timeout
        if (rx_lock) begin
          state_d = ACTIVE;
        end else if (to_cnt_q == TO_LAST) begin
          retry_d = retry_inc;
          if (retry_inc == RT_MAX) begin
            state_d = DISABLED;
            error_d = 1'b1;
          end else begin
            state_d = TRAIN;
          end
        end
      end
      ACTIVE: begin
        active_d = 1'b1;
        if (xfer) begin
          data_d  = data_in;
          valid_d = 1'b1;
        end else begin
          data_d  = IDLE_WORD;
        end
        if (skip_due) state_d = SKIP;
      end
      SKIP: begin
        data_d   = SKP_WORD;
        valid_d  = 1'b1;
        active_d = 1'b1;
        if (skip_done) state_d = ACTIVE;
      end
      default: state_d = DISABLED;
    endcase

    // Overrides that apply regardless of the per-state decision
    if (!link_enable) begin
      state_d = DISABLED;
      retry_d = '0;
      error_d = 1'b0;
    end else if (!rx_lock && is_link_up(state_q)) begin
      state_d = TRAIN;
    end

    // Going down silences the lane on the same edge rather than one later
    if (state_d == DISABLED) begin
      data_d   = '0;
      valid_d  = 1'b0;
      active_d = 1'b0;
    end

    link_up_d = is_link_up(state_d);

    // Counters advance only while staying in their state; any entry restarts
    ts_cnt_d = (state_q == TRAIN && state_d == TRAIN) ? ts_cnt_q + TSW'(1) : '0;
    to_cnt_d = (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ? to_cnt_q + TOW'(1) : '0;
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q    <= DISABLED;
      ts_cnt_q   <= '0;
      to_cnt_q   <= '0;
      retry_q    <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
      link_up    <= 1'b0;
      link_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_cnt_q   <= ts_cnt_d;
      to_cnt_q   <= to_cnt_d;
      retry_q    <= retry_d;
      data_out   <= data_d;
      valid_out  <= valid_d;
      active_out <= active_d;
      link_up    <= link_up_d;
      link_error <= error_d;
    end
  end

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phy_tx_link_ctrl
// Directed bench for phy_tx_link_ctrl with hand-computed cycle timelines.
// Edge numbering below counts rising edges after link_enable is raised.
// ---------------------------------------------------------------------------
module tb_phy_tx_link_ctrl;

  localparam logic [31:0] TS1_W  = 32'hBC4A4A4A;
  localparam logic [31:0] SKP_W  = 32'hBC1C1C1C;
  localparam logic [31:0] IDLE_W = 32'h7C7C7C7C;

  // ---------------- clock / reset ----------------
  logic        clk_f       = 1'b0;
  logic        reset       = 1'b1;
  logic        link_enable = 1'b0;
  logic        rx_lock     = 1'b0;
  logic [31:0] data_in     = '0;
  logic        valid_in    = 1'b0;
  logic        ready_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active_out;
  logic        link_up;
  logic        link_error;

  always #5 clk_f = ~clk_f;

  phy_tx_link_ctrl dut (
    .clk_f       (clk_f),
    .reset       (reset),
    .link_enable (link_enable),
    .rx_lock     (rx_lock),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active_out  (active_out),
    .link_up     (link_up),
    .link_error  (link_error)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          p = 0;        // model position: 0..62 accept, 63 skip due, 64..65 SKP words
  int          seen_skp = 0;
  int          blocked = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] d, input logic v,
                            input logic a, input logic u, input logic e);
    check({tag, ".data"},   data_out,          d);
    check({tag, ".valid"},  32'(valid_out),    32'(v));
    check({tag, ".active"}, 32'(active_out),   32'(a));
    check({tag, ".up"},     32'(link_up),      32'(u));
    check({tag, ".err"},    32'(link_error),   32'(e));
  endtask

  // One cycle in ACTIVE/SKIP with lock held; expectations follow the model p
  task automatic active_step(input logic vin, input logic [31:0] din);
    logic        exp_rdy;
    logic [31:0] e;
    valid_in = vin;
    data_in  = din;
    #1;
    exp_rdy = (p < 63);
    check("ready", 32'(ready_out), 32'(exp_rdy));
    if (!ready_out) blocked++;
    if (vin && exp_rdy) exp_q.push_back(din);
    tick();
    if (valid_out && data_out == SKP_W) seen_skp++;
    if (p >= 64) begin
      check_outs("skp", SKP_W, 1'b1, 1'b1, 1'b1, 1'b0);
    end else if (vin && exp_rdy) begin
      e = exp_q.pop_front();
      check_outs("payload", e, 1'b1, 1'b1, 1'b1, 1'b0);
    end else begin
      check_outs("idle", IDLE_W, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    p = (p == 65) ? 0 : p + 1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int tsn;

    // Reset state
    #12;
    check_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.ready", 32'(ready_out), 32'h0);
    reset       = 1'b0;
    link_enable = 1'b1;
    rx_lock     = 1'b0;

    // 1. Bring-up: E1 leaves DISABLED, E2..E17 TRAIN, E18.. WAIT_LOCK,
    //    lock raised after E20 so E21 moves to ACTIVE.
    tsn = 0;
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (valid_out && data_out == TS1_W) tsn++;
      if (i == 1) check_outs("bu_e1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (i < 21) check_outs("bu_ts1", TS1_W, 1'b1, 1'b1, 1'b0, 1'b0);
      else check_outs("bu_lock", TS1_W, 1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 20) rx_lock = 1'b1;
    end
    check("bu_ts1_count", tsn, 20);
    p = 0;

    // 2. Payload and handshake with idle gaps
    active_step(1'b1, 32'hA5A5_0001);
    active_step(1'b1, 32'hA5A5_0002);
    active_step(1'b0, 32'h0);
    active_step(1'b1, 32'hA5A5_0003);
    active_step(1'b0, 32'h0);
    active_step(1'b1, 32'hA5A5_0004);
    active_step(1'b1, 32'hA5A5_0005);
    active_step(1'b0, 32'h0);

    // 3. Continuous valid_in across exactly one SKP insertion (p 8..87)
    seen_skp = 0;
    blocked  = 0;
    for (int i = 0; i < 80; i++) active_step(1'b1, 32'hC000_0000 + 32'(i));
    check("skp_words", seen_skp, 2);
    check("skp_blocked", blocked, 3);
    check("sb_empty", exp_q.size(), 0);

    // 5. Retrain: lock drops for one cycle in ACTIVE
    rx_lock  = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hDEAD_0001;
    #1;
    check("rt_ready", 32'(ready_out), 32'h0);
    tick();
    check_outs("rt_drop", IDLE_W, 1'b0, 1'b1, 1'b0, 1'b0);
    rx_lock  = 1'b1;
    valid_in = 1'b0;
    // Lock is high throughout TRAIN but only honoured in WAIT_LOCK
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i < 17) check_outs("rt_train", TS1_W, 1'b1, 1'b1, 1'b0, 1'b0);
      else check_outs("rt_up", TS1_W, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    p = 0;
    active_step(1'b1, 32'hA5A5_0006);

    // Disable from ACTIVE silences outputs on the next edge
    link_enable = 1'b0;
    valid_in    = 1'b1;
    #1;
    check("dis_ready", 32'(ready_out), 32'h0);
    tick();
    check_outs("dis", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    valid_in = 1'b0;

    // 4. Timeout and error: each attempt 16 TRAIN + 255 WAIT_LOCK edges,
    //    third timeout lands on E814.
    rx_lock     = 1'b0;
    link_enable = 1'b1;
    for (int i = 1; i <= 814; i++) begin
      tick();
      if (i == 1) check_outs("to_e1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 272 || i == 273 || i == 813)
        check_outs("to_ts1", TS1_W, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 814) check_outs("to_err", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs("err_hold", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    link_enable = 1'b0;
    tick();
    check_outs("err_clear", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Lock arriving on the timeout cycle (X271 = 255th WAIT_LOCK edge) wins
    link_enable = 1'b1;
    for (int i = 0; i <= 270; i++) begin
      tick();
      if (i == 270) check_outs("lw_pre", TS1_W, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    rx_lock = 1'b1;
    tick();
    check_outs("lw_lock", TS1_W, 1'b1, 1'b1, 1'b1, 1'b0);
    p = 0;

    // 6. Asynchronous reset mid-payload, between edges
    active_step(1'b1, 32'hF000_0001);
    active_step(1'b1, 32'hF000_0002);
    valid_in = 1'b1;
    data_in  = 32'hF000_0003;
    #3;
    reset = 1'b1;
    #1;
    check_outs("arst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst.ready", 32'(ready_out), 32'h0);
    #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    // Restart: E1 leaves DISABLED, E2..E17 TRAIN, E18 lock seen -> ACTIVE
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 17) check_outs("rs_train", TS1_W, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 18) check_outs("rs_up", TS1_W, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    p = 0;
    active_step(1'b1, 32'hF000_0010);
    active_step(1'b0, 32'h0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
